// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with a per-grant hold limit.
//
// A rotating priority pointer gives fair access to one shared resource.
// A grant lasts at most MAX_HOLD cycles. When the last permitted cycle ends
// with the owner still requesting and not done, the arbiter revokes the grant
// and pulses timeout for one cycle. Every output is decoded from flops only.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req[0:3]   level-sensitive request lines; req[i] belongs to requester i
//   done       current owner finished; releases the grant at the next edge
//   gnt[0:3]   one-hot grant; gnt[i] high means requester i owns the resource
//   gnt_idx    binary index of the current owner
//   gnt_valid  a grant is active
//   timeout    one-cycle pulse after a grant is revoked by the hold limit
module rr_arbiter4 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:3] req,
    input  logic       done,
    output logic [0:3] gnt,
    output logic [0:1] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [1:0]      owner, owner_nxt;
    logic [1:0]      ptr, ptr_nxt;
    logic [HC_W-1:0] hold_cnt, hold_cnt_nxt;
    logic            timeout_q, timeout_nxt;

    logic            any_req;
    logic            hold_expired;
    logic            release_grant;
    logic [1:0]      owner_plus1;

    // First requester at or after p, wrapping mod 4. The loop runs from the
    // farthest offset down to offset 0, so the nearest requester wins.
    function automatic logic [1:0] sel(input logic [1:0] p, input logic [0:3] r);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign any_req       = |req;
    assign owner_plus1   = owner + 2'd1;
    assign hold_expired  = (hold_cnt == HOLD_LAST);
    assign release_grant = done || !req[owner] || hold_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 2'd0;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        timeout_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt    = GRANT;
                    owner_nxt    = sel(ptr, req);
                    hold_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    ptr_nxt      = owner_plus1;
                    hold_cnt_nxt = '0;
                    // done takes precedence: a simultaneous done is an
                    // orderly release, not a revocation.
                    timeout_nxt  = hold_expired && req[owner] && !done;
                    if (any_req) begin
                        // Old owner is searched last, so it only wins
                        // again when nobody else is asking.
                        owner_nxt = sel(owner_plus1, req);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt + HC_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign gnt_valid = (state == GRANT);
    assign gnt_idx   = owner;
    assign timeout   = timeout_q;

    always_comb begin
        gnt = '0;
        if (state == GRANT) gnt[owner] = 1'b1;
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Testbench for rr_arbiter4 (MAX_HOLD = 4).
// Each task drives its stimulus cycle by cycle. For every cycle it pushes the
// expected {gnt_valid, gnt_idx, timeout, gnt} onto a scoreboard queue, then
// pops that entry and compares it with the DUT 1 time unit after the edge.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [0:3] req;
    logic       done;
    logic [0:3] gnt;
    logic [0:1] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sb[$];
    logic [7:0] got;
    logic [7:0] want;

    rr_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected output vector built from an owner index.
    function automatic logic [7:0] ex(input logic v, input logic [1:0] idx, input logic to);
        logic [0:3] g;
        g = '0;
        if (v) g[idx] = 1'b1;
        return {v, idx, to, g};
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sb.push_back(ex(1'b0, 2'd0, 1'b0));
            if (c == 0) #1;
            else begin
                @(posedge clk);
                #1;
            end
            got  = {gnt_valid, gnt_idx, timeout, gnt};
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL reset_hold c%0d: got %b want %b", c, got, want);
            end
        end
        rst = 1'b0;
        sb.push_back(ex(1'b1, 2'd0, 1'b0));
        @(posedge clk);
        #1;
        got  = {gnt_valid, gnt_idx, timeout, gnt};
        want = sb.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL reset_first_grant: got %b want %b", got, want);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] own[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            done = 1'b1;  // in cycle 0 the FSM is IDLE, where done is ignored
            sb.push_back(ex(1'b1, own[c], 1'b0));
            @(posedge clk);
            #1;
            got  = {gnt_valid, gnt_idx, timeout, gnt};
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL round_robin c%0d: got %b want %b", c, got, want);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_hold_limit();
        logic [0:3] rq[10]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
        logic [1:0] own[10] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
        logic       to[10]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req  = rq[c];
            done = 1'b0;
            sb.push_back(ex(1'b1, own[c], to[c]));
            @(posedge clk);
            #1;
            got  = {gnt_valid, gnt_idx, timeout, gnt};
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL hold_limit c%0d: got %b want %b", c, got, want);
            end
        end
    endtask

    task automatic test_release();
        logic [0:3] rq[6]  = '{4'b0100, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b1111};
        logic       v[6]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0] own[6] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req  = rq[c];
            done = 1'b0;
            sb.push_back(ex(v[c], own[c], 1'b0));
            @(posedge clk);
            #1;
            got  = {gnt_valid, gnt_idx, timeout, gnt};
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL release c%0d: got %b want %b", c, got, want);
            end
        end
    endtask

    task automatic test_done_timeout();
        logic       dn[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       to[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            done = dn[c];
            sb.push_back(ex(1'b1, 2'd3, to[c]));
            @(posedge clk);
            #1;
            got  = {gnt_valid, gnt_idx, timeout, gnt};
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL done_timeout c%0d: got %b want %b", c, got, want);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req  = 4'b1111;
        done = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sb.push_back(ex(1'b1, 2'(c), 1'b0));
            @(posedge clk);
            #1;
            got  = {gnt_valid, gnt_idx, timeout, gnt};
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL async_setup c%0d: got %b want %b", c, got, want);
            end
        end
        done = 1'b0;
        // Owner is 3 and ptr is 3; reset lands mid-cycle with no clock edge.
        #3;
        rst = 1'b1;
        sb.push_back(ex(1'b0, 2'd0, 1'b0));
        #1;
        got  = {gnt_valid, gnt_idx, timeout, gnt};
        want = sb.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL async_reset_immediate: got %b want %b", got, want);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Requesters 1 and 3: a cleared ptr picks 1, a stale ptr of 3 would pick 3.
        req = 4'b0101;
        sb.push_back(ex(1'b1, 2'd1, 1'b0));
        @(posedge clk);
        #1;
        got  = {gnt_valid, gnt_idx, timeout, gnt};
        want = sb.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL async_reset_regrant: got %b want %b", got, want);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        test_reset();
        test_round_robin();
        test_hold_limit();
        test_release();
        test_done_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
